tx_frame_source: RTL
====================

# tx_frame_source

Transmit-side payload generator for the RMII Ethernet path. On a trigger it emits one frame body as a dibit AXI-style stream: EtherType, a captured 32-bit data word, then zero padding to the Ethernet minimum payload. It sits directly upstream of `identity`, which prepends the destination and source MACs. Downstream of that are `bitorder` (output side) and `tether`. `tether` adds the preamble, SFD and FCS; this block emits none of those.

## Interface
- `ETHERTYPE`, 16'h88B5: EtherType emitted as the first two bytes.
- `IFG_CYCLES`, 48: idle clocks forced after each frame (12 byte times at 4 dibits per byte).
- `clk` input 1: dibit clock (`eth_refclk`, 50 MHz).
- `rst` input 1: asynchronous, active-high reset; clears all state immediately.
- `trigger` input 1: single-cycle request to send a frame.
- `data_in` input 32: word to send, sampled in the cycle `trigger` is high.
- `axiov` output 1: dibit valid, registered.
- `axiod` output 2: dibit data, registered, MSB-first within each byte.
- `busy` output 1: high from trigger acceptance until the inter-frame gap (IFG) ends.
- `dropped` output 1: one-cycle pulse when a trigger is discarded.

## Operation
- Frame body is 48 bytes, sent as 192 dibits:
  - bytes 0–1: `ETHERTYPE`, MSB byte first;
  - bytes 2–5: `data_in[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`;
  - bytes 6–47: 8'h00.
- Within each byte, dibits go out as `[7:6]`, `[5:4]`, `[3:2]`, `[1:0]`. Downstream `bitorder` reverses this to wire order.
- States:
  - IDLE: on `trigger`, latch `data_in` and go to TYPE.
  - TYPE: 8 dibits, then DATA.
  - DATA: 16 dibits, then PAD.
  - PAD: 168 dibits, then GAP.
  - GAP: `IFG_CYCLES` cycles with `axiov` = 0. Then go to TYPE if the pending flag is set, otherwise IDLE.
- Dibit counter is 8 bits wide and resets to 0 on every state entry.
- The byte/dibit index is derived from the counter. The shift register is loaded at byte boundaries.
- `axiov` = 1 exactly in TYPE, DATA and PAD. It never drops mid-frame.
- Pending slot (one deep):
  - A `trigger` in any state other than IDLE, with the pending flag clear, sets the flag and latches `data_in` into the pending register.
  - A `trigger` while the pending flag is already set is discarded and pulses `dropped`. The pending data is unchanged.
  - On GAP→TYPE, the pending register is copied to the active word and the pending flag is cleared.
- A `trigger` in the same cycle as GAP→IDLE (last GAP cycle, flag clear) is treated as a pending request. The next frame follows with no extra idle cycle beyond the gap.
- Reset, including mid-frame:
  - `axiov` = 0, `axiod` = 2'b00, `busy` = 0, `dropped` = 0, state IDLE, pending flag and counters cleared.
  - A truncated frame is not resumed.

## Timing
- Trigger sampled high at edge N (IDLE): first dibit (`ETHERTYPE[15:14]`) appears with `axiov` = 1 after edge N+1.
- `busy` goes high after edge N+1, in the same cycle as `axiov`.
- `axiov` stays high for exactly 192 consecutive cycles.
- After the frame, `axiov` is low for exactly `IFG_CYCLES` cycles. `busy` is high throughout.
- Frame-to-frame spacing for a pending request is 192 + `IFG_CYCLES` cycles from first dibit to first dibit.
- `dropped` rises one cycle after the offending trigger edge.
- `axiod` = 2'b00 whenever `axiov` = 0.
- No combinational path from input to output.

## Test plan
- Reset then idle: `axiov`, `busy` and `dropped` are 0 and `axiod` = 00 for 100 cycles with no trigger.
- Single trigger with `data_in` = 32'hBEEFCAFE:
  - first 8 dibits are 10,00,10,00,10,11,01,01;
  - next 16 dibits are 10,11,11,10, 11,10,11,11, 11,00,10,10, 11,11,11,10;
  - then 168 dibits of 00;
  - `axiov` high for exactly 192 cycles, then low for 48.
- Trigger with 32'h00000001 at frame dibit 50, then 32'h0000FFFF at dibit 60:
  - the first trigger is pended and the second pulses `dropped`;
  - the second frame starts exactly 240 cycles after the first frame's first dibit and carries 32'h00000001.
- `rst` asserted at dibit 100 of a frame: `axiov` drops in the same cycle (asynchronous). A trigger 5 cycles after release produces a complete fresh 192-dibit frame.
- Trigger on the last GAP cycle with the pending flag clear: the next frame begins on the cycle immediately after the gap, with no dropped pulse.

Source files
------------

// File: rtl/tx_frame_source.sv
// Transmit frame-body generator: EtherType, one captured 32-bit word, then zero pad,
// streamed as MSB-first dibits, followed by a forced inter-frame gap.
module tx_frame_source #(
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned IFG_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [31:0] data_in,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        busy,
  output logic        dropped
);

  typedef enum logic [2:0] {StIdle, StType, StData, StPad, StGap} state_e;

  localparam logic [7:0] TypeLast = 8'd7;
  localparam logic [7:0] DataLast = 8'd15;
  localparam logic [7:0] PadLast  = 8'd167;
  localparam logic [7:0] GapLast  = 8'(IFG_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  sr_q;
  logic [31:0] word_q;
  logic [31:0] pend_data_q;
  logic        pend_q;

  logic [7:0] cur_byte;
  logic       load;
  logic [1:0] dibit;
  logic [7:0] sr_next;

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      StType: cur_byte = cnt_q[2] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
      StData: begin
        case (cnt_q[3:2])
          2'd0: cur_byte = word_q[31:24];
          2'd1: cur_byte = word_q[23:16];
          2'd2: cur_byte = word_q[15:8];
          2'd3: cur_byte = word_q[7:0];
        endcase
      end
      default: cur_byte = 8'h00;
    endcase
  end

  // A new byte enters the shift register on the first dibit of every byte.
  assign load    = (cnt_q[1:0] == 2'b00);
  assign dibit   = load ? cur_byte[7:6] : sr_q[7:6];
  assign sr_next = load ? {cur_byte[5:0], 2'b00} : {sr_q[5:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      sr_q        <= 8'd0;
      word_q      <= 32'd0;
      pend_data_q <= 32'd0;
      pend_q      <= 1'b0;
      axiov       <= 1'b0;
      axiod       <= 2'b00;
      busy        <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      dropped <= 1'b0;
      busy    <= (state_q != StIdle);

      if (trigger && state_q != StIdle) begin
        if (pend_q) begin
          dropped <= 1'b1;
        end else begin
          pend_q      <= 1'b1;
          pend_data_q <= data_in;
        end
      end

      unique case (state_q)
        StIdle: begin
          axiov <= 1'b0;
          axiod <= 2'b00;
          if (trigger) begin
            word_q  <= data_in;
            cnt_q   <= 8'd0;
            state_q <= StType;
          end
        end
        StType, StData, StPad: begin
          axiov <= 1'b1;
          axiod <= dibit;
          sr_q  <= sr_next;
          cnt_q <= cnt_q + 8'd1;
          if (state_q == StType && cnt_q == TypeLast) begin
            cnt_q   <= 8'd0;
            state_q <= StData;
          end else if (state_q == StData && cnt_q == DataLast) begin
            cnt_q   <= 8'd0;
            state_q <= StPad;
          end else if (state_q == StPad && cnt_q == PadLast) begin
            cnt_q   <= 8'd0;
            state_q <= StGap;
          end
        end
        StGap: begin
          axiov <= 1'b0;
          axiod <= 2'b00;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == GapLast) begin
            cnt_q <= 8'd0;
            if (pend_q) begin
              word_q  <= pend_data_q;
              pend_q  <= 1'b0;
              state_q <= StType;
            end else if (trigger) begin
              // Trigger on the final gap cycle chains straight into the next frame.
              word_q  <= data_in;
              pend_q  <= 1'b0;
              state_q <= StType;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
